// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - Parametrised valid/ready pipeline stage register with stall, flush and optional skid entry
//
// Build option: define PIPE_STAGE_SKID_EN for a two-entry (main + skid) stage
// with a registered in_ready. Without it the stage holds a single entry and
// in_ready is combinational.

module pipe_stage_reg #(
  parameter int                CTRL_W   = 9,
  parameter int                DATA_W   = 143,
  parameter logic [DATA_W-1:0] DATA_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic              w_in_fire;

`ifdef PIPE_STAGE_SKID_EN

  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;
  logic              w_main_free;

  // Ready comes straight from a flop, so it never depends on out_ready.
  assign in_ready    = !r_skid_valid;
  assign w_in_fire   = in_valid & in_ready;
  // Main entry can take new contents this edge (empty or being drained).
  assign w_main_free = !r_valid | out_ready;

  // Main valid: refilled from skid first (FIFO order), otherwise from input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_main_free) begin
      r_valid <= r_skid_valid | w_in_fire;
    end
  end

  // Main payload: written only when something actually moves into it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_data <= DATA_RST;
    end else if (!flush && w_main_free) begin
      if (r_skid_valid) begin
        r_ctrl <= r_skid_ctrl;
        r_data <= r_skid_data;
      end else if (w_in_fire) begin
        r_ctrl <= in_ctrl;
        r_data <= in_data;
      end
    end
  end

  // Skid valid: fills when input arrives while main is stalled, empties when main frees.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_main_free) begin
      r_skid_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_skid_valid <= 1'b1;
    end
  end

  // Skid payload: captures the input that could not go to a stalled main entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_ctrl <= '0;
      r_skid_data <= DATA_RST;
    end else if (!flush && !w_main_free && w_in_fire) begin
      r_skid_ctrl <= in_ctrl;
      r_skid_data <= in_data;
    end
  end

`else

  // Accept when empty, draining, or flushing (flush discards input, so never block upstream).
  assign in_ready  = flush | !r_valid | out_ready;
  assign w_in_fire = in_valid & in_ready;

  // Valid: cleared by flush, otherwise follows the input whenever the slot opens.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (in_ready) begin
      r_valid <= in_valid;
    end
  end

  // Payload: loaded only on an accepted input so idle cycles do not toggle it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= '0;
      r_data <= DATA_RST;
    end else if (!flush && w_in_fire) begin
      r_ctrl <= in_ctrl;
      r_data <= in_data;
    end
  end

`endif

  // A bubble must never carry write enables, so control is gated by valid.
  assign out_valid = r_valid;
  assign out_ctrl  = r_valid ? r_ctrl : '0;
  assign out_data  = r_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - Directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

  localparam int CTRL_W = 9;
  localparam int DATA_W = 143;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  int   checks   = 0;
  int   failures = 0;
  logic acc;

  pipe_stage_reg #(
    .CTRL_W  (CTRL_W),
    .DATA_W  (DATA_W),
    .DATA_RST('0)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [159:0] got, input logic [159:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Settle, note whether the input handshake fires, clock once, sample 1 ns after the edge.
  task automatic step();
    #1;
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values with no clock edge yet
    in_ctrl = 9'h1FF;
    #2;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_ctrl", out_ctrl, 0);
    check_eq("rst_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    // Back-to-back stream, one cycle latency, no gaps
    out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_ctrl  = 9'h1FF;
      in_data  = DATA_W'(i);
      step();
      check_eq("stream_valid", out_valid, 1);
      check_eq("stream_data", out_data, i);
      check_eq("stream_ctrl", out_ctrl, 9'h1FF);
    end
    in_valid = 1'b0;
    step();
    check_eq("stream_end_valid", out_valid, 0);

    // Bubble: control on the input must not leak while invalid; data held
    in_ctrl = 9'h1FF;
    in_data = 'h99;
    step();
    check_eq("bubble_ctrl", out_ctrl, 0);
    check_eq("bubble_valid", out_valid, 0);
    check_eq("bubble_data_hold", out_data, 5);

    // Stall with 0xA5 held, 0xA6 waiting upstream
    in_valid = 1'b1;
    in_data  = 'hA5;
    in_ctrl  = 9'h0AA;
    step();
    check_eq("stall_load", out_data, 'hA5);
    out_ready = 1'b0;
    in_data   = 'hA6;
    in_ctrl   = 9'h055;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    check_eq("stall_ready_pre", in_ready, 1);
`else
    check_eq("stall_ready_pre", in_ready, 0);
`endif
    for (int k = 0; k < 3; k++) begin
      step();
      if (acc) in_valid = 1'b0;
      check_eq("stall_valid", out_valid, 1);
      check_eq("stall_data", out_data, 'hA5);
      check_eq("stall_ctrl", out_ctrl, 9'h0AA);
      check_eq("stall_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    if (acc) in_valid = 1'b0;
    check_eq("release_valid", out_valid, 1);
    check_eq("release_data", out_data, 'hA6);
    check_eq("release_ctrl", out_ctrl, 9'h055);
    step();
    check_eq("release_drain", out_valid, 0);

    // Flush with held 0x66 and incoming 0x77
    in_valid  = 1'b1;
    in_data   = 'h66;
    in_ctrl   = 9'h1FF;
    out_ready = 1'b0;
    step();
    check_eq("flush_load", out_data, 'h66);
    flush   = 1'b1;
    in_data = 'h77;
    #1;
    check_eq("flush_in_ready", in_ready, 1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_valid", out_valid, 0);
    check_eq("flush_ctrl", out_ctrl, 0);
    check_eq("flush_data_kept", out_data, 'h66);
    out_ready = 1'b1;
    step();
    check_eq("flush_after_valid", out_valid, 0);

    // Flush while stalled with the stage full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 'hB1;
    step();
    in_data = 'hB2;
    step();
    in_valid = 1'b0;
    #1;
    check_eq("full_ready", in_ready, 0);
    flush = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    check_eq("full_flush_ready", in_ready, 0);
`else
    check_eq("full_flush_ready", in_ready, 1);
`endif
    step();
    flush = 1'b0;
    check_eq("full_flush_valid", out_valid, 0);
    check_eq("full_flush_ctrl", out_ctrl, 0);
    check_eq("full_flush_ready_after", in_ready, 1);
    out_ready = 1'b1;
    step();
    check_eq("full_flush_no_skid", out_valid, 0);

    // Asynchronous reset mid-cycle with an entry held
    in_valid = 1'b1;
    in_data  = 'h5A;
    in_ctrl  = 9'h1FF;
    step();
    check_eq("arst_load", out_valid, 1);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", out_valid, 0);
    check_eq("arst_ctrl", out_ctrl, 0);
    check_eq("arst_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
